// File: rtl/tcb_arb.sv
// tcb_arb: round-robin arbiter sharing one TCB manager port among N requesting managers.
// Optional feature macro TCB_ARB_LOCK_EN: sub_lck keeps the grant on one port across transfers.
module tcb_arb #(
  parameter int N   = 2,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int SW  = 8,
  parameter int DLY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          sub_vld,
  input  logic [N-1:0]          sub_wen,
  input  logic [N*(DW/SW)-1:0]  sub_ben,
  input  logic [N*AW-1:0]       sub_adr,
  input  logic [N*DW-1:0]       sub_wdt,
  input  logic [N-1:0]          sub_lck,
  output logic [N-1:0]          sub_rdy,
  output logic [N*DW-1:0]       sub_rdt,
  output logic [N-1:0]          sub_err,
  output logic                  man_vld,
  output logic                  man_wen,
  output logic [DW/SW-1:0]      man_ben,
  output logic [AW-1:0]         man_adr,
  output logic [DW-1:0]         man_wdt,
  input  logic                  man_rdy,
  input  logic [DW-1:0]         man_rdt,
  input  logic                  man_err
);

  localparam int BW = DW / SW;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Handshake: a transfer happens in the cycle where man_vld & man_rdy; a requester that sees
  // vld high without rdy must keep its request stable until the cycle it sees sub_rdy high.
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] hold_id_q, hold_id_d;
  logic          hold_q, hold_d;
  logic [IW-1:0] gnt;
  logic          xfer;

  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    logic          found;
    sum   = '0;
    cand  = '0;
    found = hold_q;
    gnt   = hold_id_q;
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!found && sub_vld[cand]) begin
        gnt   = cand;
        found = 1'b1;
      end
    end
  end

  assign man_vld = rst & (|sub_vld);
  assign xfer    = man_vld & man_rdy;

  always_comb begin
    man_wen = 1'b0;
    man_ben = '0;
    man_adr = '0;
    man_wdt = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == IW'(i)) begin
        man_wen = sub_wen[i];
        man_ben = sub_ben[i*BW +: BW];
        man_adr = sub_adr[i*AW +: AW];
        man_wdt = sub_wdt[i*DW +: DW];
      end
    end
  end

  always_comb begin
    sub_rdy = '0;
    if (rst) sub_rdy[gnt] = man_rdy;
  end

  always_comb begin
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    hold_id_d = hold_id_q;
    if (xfer) begin
`ifdef TCB_ARB_LOCK_EN
      if (sub_lck[gnt]) begin
        hold_d    = 1'b1;
        hold_id_d = gnt;
      end else begin
        ptr_d  = gnt;
        hold_d = 1'b0;
      end
`else
      ptr_d  = gnt;
      hold_d = 1'b0;
`endif
    end else if (man_vld) begin
      hold_d    = 1'b1;
      hold_id_d = gnt;
    end
    // A holder that withdraws its request releases the grant.
    if (hold_q && !sub_vld[hold_id_q]) hold_d = 1'b0;
  end

`ifndef TCB_ARB_LOCK_EN
  logic unused_lck;
  assign unused_lck = ^sub_lck;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q     <= IW'(N-1);
      hold_q    <= 1'b0;
      hold_id_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      hold_id_q <= hold_id_d;
    end
  end

  logic          resp_v;
  logic [IW-1:0] resp_id;

  if (DLY == 0) begin : g_nodly
    assign resp_v  = xfer;
    assign resp_id = gnt;
  end else begin : g_pipe
    logic [DLY-1:0] v_q, v_d;
    logic [IW-1:0]  id_q [DLY];
    logic [IW-1:0]  id_d [DLY];

    always_comb begin
      v_d[0]  = xfer;
      id_d[0] = gnt;
      for (int s = 1; s < DLY; s++) begin
        v_d[s]  = v_q[s-1];
        id_d[s] = id_q[s-1];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        v_q <= '0;
        for (int s = 0; s < DLY; s++) id_q[s] <= '0;
      end else begin
        v_q  <= v_d;
        id_q <= id_d;
      end
    end

    assign resp_v  = v_q[DLY-1];
    assign resp_id = id_q[DLY-1];
  end

  // Responses in flight across a reset are dropped: the pipe is cleared and outputs gated.
  always_comb begin
    sub_rdt = '0;
    sub_err = '0;
    for (int i = 0; i < N; i++) begin
      if (rst && resp_v && resp_id == IW'(i)) begin
        sub_rdt[i*DW +: DW] = man_rdt;
        sub_err[i]          = man_err;
      end
    end
  end

endmodule

// File: tb/tb_tcb_arb.sv
// Bench for tcb_arb: four instances (DLY=0..3, N=4) share stimulus; a spec-level model
// (grant scan, transfer history queue) supplies the expected grant and response routing.
module tb_tcb_arb;
  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = 8;
  localparam int BW   = DW / SW;
  localparam int BENW = N * BW;
  localparam int ND   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    sub_vld, sub_wen, sub_lck;
  logic [BENW-1:0] sub_ben;
  logic [N*AW-1:0] sub_adr;
  logic [N*DW-1:0] sub_wdt;
  logic            man_rdy, man_err;
  logic [DW-1:0]   man_rdt;

  logic [N-1:0]    o_sub_rdy [ND];
  logic [N*DW-1:0] o_sub_rdt [ND];
  logic [N-1:0]    o_sub_err [ND];
  logic            o_man_vld [ND];
  logic            o_man_wen [ND];
  logic [BW-1:0]   o_man_ben [ND];
  logic [AW-1:0]   o_man_adr [ND];
  logic [DW-1:0]   o_man_wdt [ND];

  for (genvar k = 0; k < ND; k++) begin : g_dut
    tcb_arb #(.N(N), .AW(AW), .DW(DW), .SW(SW), .DLY(k)) u_dut (
      .clk(clk), .rst(rst),
      .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_ben(sub_ben), .sub_adr(sub_adr),
      .sub_wdt(sub_wdt), .sub_lck(sub_lck),
      .sub_rdy(o_sub_rdy[k]), .sub_rdt(o_sub_rdt[k]), .sub_err(o_sub_err[k]),
      .man_vld(o_man_vld[k]), .man_wen(o_man_wen[k]), .man_ben(o_man_ben[k]),
      .man_adr(o_man_adr[k]), .man_wdt(o_man_wdt[k]),
      .man_rdy(man_rdy), .man_rdt(man_rdt), .man_err(man_err)
    );
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: rotating pointer, hold flag and a history of transfer ids (newest first).
  int m_ptr     = N - 1;
  int m_hold    = 0;
  int m_hold_id = 0;
  int resp_q[$];

  function automatic logic [AW-1:0] port_adr(int i);
    return 32'hA000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic int m_gnt();
    if (m_hold != 0) return m_hold_id;
    for (int k = 1; k <= N; k++)
      if (sub_vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic int m_resp(int d);
    int g;
    if (!rst) return -1;
    if (d == 0) begin
      g = m_gnt();
      return (g >= 0 && man_rdy) ? g : -1;
    end
    return resp_q[d-1];
  endfunction

  function automatic logic [N*DW-1:0] e_rdt(int d);
    logic [N*DW-1:0] v;
    int id;
    v  = '0;
    id = m_resp(d);
    if (id >= 0) v[id*DW +: DW] = man_rdt;
    return v;
  endfunction

  function automatic logic [N-1:0] e_err(int d);
    logic [N-1:0] v;
    int id;
    v  = '0;
    id = m_resp(d);
    if (id >= 0) v[id] = man_err;
    return v;
  endfunction

  task automatic step();
    int g;
    bit xfer;
    g    = m_gnt();
    xfer = rst && (g >= 0) && man_rdy;
    if (!rst) begin
      m_ptr  = N - 1;
      m_hold = 0;
      resp_q = '{-1, -1, -1, -1};
    end else begin
      resp_q.push_front(xfer ? g : -1);
      void'(resp_q.pop_back());
      if (xfer) begin
`ifdef TCB_ARB_LOCK_EN
        if (sub_lck[g]) begin
          m_hold = 1; m_hold_id = g;
        end else begin
          m_ptr = g; m_hold = 0;
        end
`else
        m_ptr = g; m_hold = 0;
`endif
      end else if (g >= 0) begin
        m_hold = 1; m_hold_id = g;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic init_ports();
    for (int i = 0; i < N; i++) begin
      sub_adr[i*AW +: AW] = port_adr(i);
      sub_wdt[i*DW +: DW] = 32'hD000_0000 + 32'(i);
    end
    sub_wen = '0;
    sub_ben = '1;
    sub_lck = '0;
  endtask

  task automatic do_reset();
    init_ports();
    sub_vld = '0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic idle(int n);
    sub_vld = '0;
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic test_reset();
    init_ports();
    rst = 1'b0; sub_vld = '1; man_rdy = 1'b1; man_err = 1'b1; man_rdt = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < ND; k++) begin
        checks++; if (o_man_vld[k] !== 1'b0) begin failures++; $display("FAIL reset_man_vld dly=%0d got=%b exp=0", k, o_man_vld[k]); end
        checks++; if (o_sub_rdy[k] !== '0) begin failures++; $display("FAIL reset_sub_rdy dly=%0d got=%b exp=0", k, o_sub_rdy[k]); end
        checks++; if (o_sub_rdt[k] !== '0 || o_sub_err[k] !== '0) begin failures++; $display("FAIL reset_resp dly=%0d rdt=%h err=%b exp=0", k, o_sub_rdt[k], o_sub_err[k]); end
      end
      step();
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < ND; k++) begin
      checks++; if (o_man_adr[k] !== port_adr(0)) begin failures++; $display("FAIL first_grant_adr dly=%0d got=%h exp=%h", k, o_man_adr[k], port_adr(0)); end
      checks++; if (o_sub_rdy[k] !== 4'b0001) begin failures++; $display("FAIL first_grant_rdy dly=%0d got=%b exp=0001", k, o_sub_rdy[k]); end
    end
  endtask

  task automatic test_fairness();
    int ord[5] = '{0, 1, 2, 3, 0};
    logic [N*DW-1:0] exp_rdt;
    sub_vld = '1; man_rdy = 1'b1; man_err = 1'b0;
    for (int c = 0; c < 6; c++) begin
      man_rdt = (c > 0) ? 32'h1000 + 32'(ord[c-1]) : 32'h0;
      #1;
      if (c < 5) begin
        checks++; if (o_man_adr[1] !== port_adr(ord[c])) begin failures++; $display("FAIL fair_adr c=%0d got=%h exp=%h", c, o_man_adr[1], port_adr(ord[c])); end
        checks++; if (o_sub_rdy[1] !== 4'(1 << ord[c])) begin failures++; $display("FAIL fair_rdy c=%0d got=%b exp_port=%0d", c, o_sub_rdy[1], ord[c]); end
      end
      if (c > 0) begin
        exp_rdt = '0;
        exp_rdt[ord[c-1]*DW +: DW] = 32'h1000 + 32'(ord[c-1]);
        checks++; if (o_sub_rdt[1] !== exp_rdt) begin failures++; $display("FAIL fair_rdt c=%0d got=%h exp=%h", c, o_sub_rdt[1], exp_rdt); end
      end
      step();
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    sub_vld = 4'b0100; man_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c >= 1) sub_vld = 4'b0101;
      #1;
      for (int k = 0; k < ND; k++) begin
        checks++; if (o_man_adr[k] !== port_adr(2)) begin failures++; $display("FAIL stall_adr dly=%0d c=%0d got=%h exp=%h", k, c, o_man_adr[k], port_adr(2)); end
        checks++; if (o_sub_rdy[k] !== '0) begin failures++; $display("FAIL stall_rdy dly=%0d c=%0d got=%b exp=0", k, c, o_sub_rdy[k]); end
      end
      step();
    end
    man_rdy = 1'b1;
    #1;
    checks++; if (o_man_adr[1] !== port_adr(2)) begin failures++; $display("FAIL stall_xfer_adr got=%h exp=%h", o_man_adr[1], port_adr(2)); end
    checks++; if (o_sub_rdy[1] !== 4'b0100) begin failures++; $display("FAIL stall_xfer_rdy got=%b exp=0100", o_sub_rdy[1]); end
    step();
    sub_vld = 4'b0001;
    #1;
    checks++; if (o_man_adr[1] !== port_adr(0)) begin failures++; $display("FAIL stall_next_adr got=%h exp=%h", o_man_adr[1], port_adr(0)); end
    checks++; if (o_sub_rdy[1] !== 4'b0001) begin failures++; $display("FAIL stall_next_rdy got=%b exp=0001", o_sub_rdy[1]); end
    step();
  endtask

  task automatic test_response_routing();
    logic [N-1:0]    seq_vld [8] = '{4'b0010, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [DW-1:0]   rdt_tab [8] = '{32'h55, 32'h66, 32'h77, 32'hA, 32'hB, 32'hC, 32'h88, 32'h99};
    logic [N*DW-1:0] exp_rdt;
    logic [N-1:0]    exp_err;
    man_rdy = 1'b1; man_err = 1'b0;
    idle(4);
    for (int c = 0; c < 8; c++) begin
      sub_vld = seq_vld[c];
      man_rdt = rdt_tab[c];
      man_err = (c == 4);
      #1;
      exp_rdt = '0;
      exp_err = '0;
      case (c)
        3: exp_rdt[1*DW +: DW] = 32'hA;
        4: begin exp_rdt[3*DW +: DW] = 32'hB; exp_err[3] = 1'b1; end
        5: exp_rdt[1*DW +: DW] = 32'hC;
        default: ;
      endcase
      checks++; if (o_sub_rdt[3] !== exp_rdt) begin failures++; $display("FAIL route_rdt c=%0d got=%h exp=%h", c, o_sub_rdt[3], exp_rdt); end
      checks++; if (o_sub_err[3] !== exp_err) begin failures++; $display("FAIL route_err c=%0d got=%b exp=%b", c, o_sub_err[3], exp_err); end
      if (c < 3) begin
        checks++; if (o_sub_rdy[3] !== seq_vld[c]) begin failures++; $display("FAIL route_rdy c=%0d got=%b exp=%b", c, o_sub_rdy[3], seq_vld[c]); end
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    man_rdy = 1'b1; man_err = 1'b1; man_rdt = 32'h1234_5678;
    idle(4);
    sub_vld = 4'b0001;
    #1;
    checks++; if (o_sub_rdt[0] !== {96'h0, 32'h1234_5678}) begin failures++; $display("FAIL midrst_dly0_rdt got=%h exp=%h", o_sub_rdt[0], {96'h0, 32'h1234_5678}); end
    step();
    sub_vld = '0; rst = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      checks++; if (o_sub_rdt[k] !== '0 || o_sub_err[k] !== '0) begin failures++; $display("FAIL midrst_in_reset dly=%0d rdt=%h err=%b exp=0", k, o_sub_rdt[k], o_sub_err[k]); end
    end
    step();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      for (int k = 1; k < ND; k++) begin
        checks++; if (o_sub_rdt[k] !== '0 || o_sub_err[k] !== '0) begin failures++; $display("FAIL midrst_after dly=%0d c=%0d rdt=%h err=%b exp=0", k, c, o_sub_rdt[k], o_sub_err[k]); end
      end
      step();
    end
  endtask

`ifdef TCB_ARB_LOCK_EN
  task automatic test_lock();
    logic [N-1:0] vld_tab [6] = '{4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0101, 4'b0001};
    logic [N-1:0] lck_tab [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    int ord[6] = '{1, 1, 1, 1, 2, 0};
    do_reset();
    man_rdy = 1'b1; man_err = 1'b0;
    for (int c = 0; c < 6; c++) begin
      sub_vld = vld_tab[c];
      sub_lck = lck_tab[c];
      #1;
      checks++; if (o_man_adr[1] !== port_adr(ord[c])) begin failures++; $display("FAIL lock_adr c=%0d got=%h exp=%h", c, o_man_adr[1], port_adr(ord[c])); end
      checks++; if (o_sub_rdy[1] !== 4'(1 << ord[c])) begin failures++; $display("FAIL lock_rdy c=%0d got=%b exp_port=%0d", c, o_sub_rdy[1], ord[c]); end
      step();
    end
    sub_lck = '0;
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] v;
    logic [N-1:0] er;
    int g;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) != 0);
      v = N'($urandom);
      if (m_hold != 0) v[m_hold_id] = 1'b1;
      sub_vld = v;
      sub_wen = N'($urandom);
      sub_lck = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      sub_ben = BENW'($urandom);
      for (int i = 0; i < N; i++) begin
        sub_adr[i*AW +: AW] = $urandom;
        sub_wdt[i*DW +: DW] = $urandom;
      end
      man_rdy = ($urandom_range(0, 2) != 0);
      man_rdt = $urandom;
      man_err = 1'($urandom_range(0, 1));
      #1;
      g = m_gnt();
      er = '0;
      if (rst && g >= 0 && man_rdy) er[g] = 1'b1;
      for (int k = 0; k < ND; k++) begin
        checks++; if (o_man_vld[k] !== (rst && sub_vld != 0)) begin failures++; $display("FAIL rnd_man_vld dly=%0d c=%0d got=%b", k, c, o_man_vld[k]); end
        if (rst && g >= 0) begin
          checks++; if (o_man_adr[k] !== sub_adr[g*AW +: AW] || o_man_wdt[k] !== sub_wdt[g*DW +: DW]) begin failures++; $display("FAIL rnd_fwd dly=%0d c=%0d adr=%h wdt=%h exp_port=%0d", k, c, o_man_adr[k], o_man_wdt[k], g); end
          checks++; if (o_man_wen[k] !== sub_wen[g] || o_man_ben[k] !== sub_ben[g*BW +: BW]) begin failures++; $display("FAIL rnd_wen_ben dly=%0d c=%0d wen=%b ben=%b exp_port=%0d", k, c, o_man_wen[k], o_man_ben[k], g); end
        end
        if (!rst || g >= 0) begin
          checks++; if (o_sub_rdy[k] !== er) begin failures++; $display("FAIL rnd_rdy dly=%0d c=%0d got=%b exp=%b", k, c, o_sub_rdy[k], er); end
        end
        checks++; if (o_sub_rdt[k] !== e_rdt(k)) begin failures++; $display("FAIL rnd_rdt dly=%0d c=%0d got=%h exp=%h", k, c, o_sub_rdt[k], e_rdt(k)); end
        checks++; if (o_sub_err[k] !== e_err(k)) begin failures++; $display("FAIL rnd_err dly=%0d c=%0d got=%b exp=%b", k, c, o_sub_err[k], e_err(k)); end
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    resp_q = '{-1, -1, -1, -1};
    rst = 1'b0; sub_vld = '0; sub_wen = '0; sub_lck = '0; sub_ben = '0;
    sub_adr = '0; sub_wdt = '0; man_rdy = 1'b0; man_rdt = '0; man_err = 1'b0;
    test_reset();
    test_fairness();
    test_stall_hold();
    test_response_routing();
    test_mid_reset();
`ifdef TCB_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
